// File: rtl/ahb_sram_pkg.sv
// Shared encodings, widths and FSM state type for the AHB SRAM slave.
// Optional macro AHB_SRAM_RD_WAIT_EN adds the RD_WAIT state.
package ahb_sram_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
`ifdef AHB_SRAM_RD_WAIT_EN
    ST_RD_WAIT,
`endif
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Little-endian byte-lane enables for an aligned access.
  function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      HSIZE_BYTE: return 4'b0001 << lane;
      HSIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus signals between a master/interconnect and the SRAM slave.
interface ahb_sram_slave_if;
  import ahb_sram_pkg::*;

  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/sram_1r1w_be.sv
// Synchronous 1-read/1-write RAM with byte enables; a read colliding with a
// write to the same word returns the old data.
module sram_1r1w_be #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem_q [1 << AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < DW / 8; b++) begin
        if (be[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: zero-wait writes, registered reads with write forwarding,
// two-cycle ERROR response. Macro AHB_SRAM_RD_WAIT_EN adds one read wait state.
module ahb_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int unsigned MEM_AW = 10
) (
  input logic             hclk,
  input logic             hreset,
  ahb_sram_slave_if.slave bus
);

  state_e              state_q, state_d;
  logic [MEM_AW+1:0]   addr_q;
  logic                hwrite_q;
  logic [2:0]          hsize_q;
  logic [3:0]          fwd_be_q;
  logic [DATA_W-1:0]   fwd_data_q;
  logic                accept, addr_err, rd_accept, wr_active;
  logic [3:0]          wr_be;
  logic [DATA_W-1:0]   ram_rdata, rd_merged;
  logic                unused_ok;

  assign unused_ok = ^bus.hburst;

  assign accept = bus.hsel && bus.hready && !hreset &&
                  (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);

  assign addr_err = ((bus.haddr >> (MEM_AW + 2)) != '0) ||
                    (bus.hsize > HSIZE_WORD) ||
                    (bus.hsize == HSIZE_HALF && bus.haddr[0]) ||
                    (bus.hsize == HSIZE_WORD && bus.haddr[1:0] != 2'b00);

  assign rd_accept = accept && !addr_err && !bus.hwrite;
  // Gating with hreset drops a write whose data phase is cut short by reset.
  assign wr_active = (state_q == ST_WRITE) && hwrite_q && !hreset;
  assign wr_be     = lane_be(hsize_q, addr_q[1:0]);

  sram_1r1w_be #(.AW(MEM_AW), .DW(DATA_W)) u_ram (
    .clk   (hclk),
    .we    (wr_active),
    .be    (wr_be),
    .waddr (addr_q[MEM_AW+1:2]),
    .wdata (bus.hwdata),
    .re    (rd_accept),
    .raddr (bus.haddr[MEM_AW+1:2]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge hclk) begin
    if (hreset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // The RAM returns pre-write data on collision, so lanes written in the same
  // cycle as the read address phase are captured here and merged later.
  always_ff @(posedge hclk) begin
    if (accept) begin
      addr_q   <= bus.haddr[MEM_AW+1:0];
      hwrite_q <= bus.hwrite;
      hsize_q  <= bus.hsize;
    end
    if (rd_accept) begin
      fwd_be_q   <= (wr_active && addr_q[MEM_AW+1:2] == bus.haddr[MEM_AW+1:2]) ? wr_be : '0;
      fwd_data_q <= bus.hwdata;
    end
  end

  always_comb begin
    rd_merged = ram_rdata;
    for (int unsigned b = 0; b < 4; b++) begin
      if (fwd_be_q[b]) rd_merged[8*b +: 8] = fwd_data_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d       = ST_IDLE;
    bus.hreadyout = 1'b1;
    bus.hresp     = HRESP_OKAY;
    bus.hrdata    = '0;

    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
`ifdef AHB_SRAM_RD_WAIT_EN
      ST_RD_WAIT: state_d = ST_READ;
`endif
      default: begin
        if (accept) begin
          if (addr_err)        state_d = ST_ERR1;
          else if (bus.hwrite) state_d = ST_WRITE;
`ifdef AHB_SRAM_RD_WAIT_EN
          else                 state_d = ST_RD_WAIT;
`else
          else                 state_d = ST_READ;
`endif
        end
      end
    endcase

    case (state_q)
      ST_ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = HRESP_ERROR;
      end
      ST_ERR2: bus.hresp  = HRESP_ERROR;
      ST_READ: bus.hrdata = rd_merged;
`ifdef AHB_SRAM_RD_WAIT_EN
      ST_RD_WAIT: bus.hreadyout = 1'b0;
`endif
      default: ;
    endcase

    if (hreset) begin
      bus.hreadyout = 1'b1;
      bus.hresp     = HRESP_OKAY;
      bus.hrdata    = '0;
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: directed scenarios plus random traffic
// against a byte-array memory model with in-order transfer semantics.
module tb_ahb_sram_slave;
  import ahb_sram_pkg::*;

  logic hclk = 1'b0;
  logic hreset;
  always #5 hclk = ~hclk;

  ahb_sram_slave_if bus();
  assign bus.hready = bus.hreadyout;

  ahb_sram_slave #(.MEM_AW(10)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  typedef enum {P_NONE, P_WR, P_RD, P_ERR} pend_e;

  int           checks = 0;
  int           errors = 0;
  logic [7:0]   mm [4096];
  pend_e        p_kind = P_NONE;
  logic [31:0]  p_addr = '0;
  logic [31:0]  p_wdata = '0;
  logic [31:0]  p_rexp = '0;
  logic [2:0]   p_size = '0;
  logic [31:0]  last_rdata;
  logic [31:0]  old_val;

  function automatic logic [31:0] mword(input logic [31:0] a);
    int unsigned b;
    b = a & 32'hFFC;
    return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
  endfunction

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
    if (a >= 32'd4096) return 1'b1;
    if (sz > 3'd2) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  task automatic mwrite(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int unsigned n, first, ba;
    n = 1 << sz;
    first = a & ~(n - 1);
    for (int unsigned k = 0; k < n; k++) begin
      ba = first + k;
      mm[ba] = d[8*(ba%4) +: 8];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
    chk("rst_hresp", 32'(bus.hresp), 32'd0);
    chk("rst_hrdata", bus.hrdata, 32'd0);
  endtask

  // Present one address phase (with the pending write's data) and check the
  // data phase of the previously accepted transfer until it completes.
  task automatic step(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    logic        e_rdy  [2];
    logic [1:0]  e_resp [2];
    logic [31:0] e_dat  [2];
    int          n;
    bus.hsel   = sel;
    bus.htrans = tr;
    bus.hwrite = wr;
    bus.haddr  = a;
    bus.hsize  = sz;
    bus.hburst = 3'($urandom);
    bus.hwdata = (p_kind == P_WR) ? p_wdata : $urandom;
    if (p_kind == P_WR) mwrite(p_addr, p_size, p_wdata);
    n = 1;
    e_rdy[0] = 1'b1; e_resp[0] = 2'd0; e_dat[0] = '0;
    e_rdy[1] = 1'b1; e_resp[1] = 2'd0; e_dat[1] = '0;
    case (p_kind)
      P_RD: begin
`ifdef AHB_SRAM_RD_WAIT_EN
        n = 2; e_rdy[0] = 1'b0; e_dat[1] = p_rexp;
`else
        e_dat[0] = p_rexp;
`endif
      end
      P_ERR: begin
        n = 2; e_rdy[0] = 1'b0; e_resp[0] = 2'd1; e_resp[1] = 2'd1;
      end
      default: ;
    endcase
    for (int i = 0; i < n; i++) begin
      @(negedge hclk);
      chk("hreadyout", 32'(bus.hreadyout), 32'(e_rdy[i]));
      chk("hresp", 32'(bus.hresp), 32'(e_resp[i]));
      chk("hrdata", bus.hrdata, e_dat[i]);
      last_rdata = bus.hrdata;
      @(posedge hclk); #1;
    end
    if (sel && tr[1]) begin
      if (is_err(a, sz)) p_kind = P_ERR;
      else if (wr) begin
        p_kind = P_WR; p_addr = a; p_size = sz; p_wdata = wd;
      end else begin
        p_kind = P_RD; p_rexp = mword(a);
      end
    end else begin
      p_kind = P_NONE;
    end
  endtask

  task automatic idle();
    step(1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
  endtask

  initial begin
    int unsigned r, r2;
    logic [31:0] a;
    logic [2:0]  sz;

    hreset = 1'b1;
    bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE; bus.hwrite = 1'b0;
    bus.haddr = '0; bus.hsize = HSIZE_WORD; bus.hburst = '0; bus.hwdata = '0;
    repeat (2) begin
      @(negedge hclk);
      chk_reset_outputs();
      @(posedge hclk); #1;
    end
    hreset = 1'b0;

    for (int w = 0; w < 64; w++) step(1'b1, HTRANS_NONSEQ, 1'b1, 32'(w * 4), HSIZE_WORD, $urandom);
    idle();

    // Word write then read back
    step(1'b1, HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
    step(1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
    idle();
    chk("word_rd", last_rdata, 32'hDEADBEEF);

    // Byte write forwarded into an overlapping read
    step(1'b1, HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'h11223344);
    step(1'b1, HTRANS_SEQ,    1'b1, 32'h13, HSIZE_BYTE, 32'hAAFFFFFF);
    step(1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
    idle();
    chk("fwd_merge", last_rdata, 32'hAA223344);

    // Out-of-range read, then a read accepted during ERR2
    step(1'b1, HTRANS_NONSEQ, 1'b0, 32'h1000, HSIZE_WORD, 32'h0);
    step(1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
    idle();
    chk("after_err_rd", last_rdata, 32'hAA223344);

    // Misaligned half write leaves memory untouched
    old_val = mword(32'h20);
    step(1'b1, HTRANS_NONSEQ, 1'b1, 32'h21, HSIZE_HALF, 32'h12345678);
    step(1'b1, HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD, 32'h0);
    idle();
    chk("misalign_untouched", last_rdata, old_val);

    // Reset in a write data phase discards the write
    old_val = mword(32'h30);
    step(1'b1, HTRANS_NONSEQ, 1'b1, 32'h30, HSIZE_WORD, 32'h55);
    hreset = 1'b1;
    bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE; bus.hwdata = 32'h55;
    @(negedge hclk);
    chk_reset_outputs();
    @(posedge hclk); #1;
    hreset = 1'b0;
    p_kind = P_NONE;
    step(1'b1, HTRANS_NONSEQ, 1'b0, 32'h30, HSIZE_WORD, 32'h0);
    idle();
    chk("rst_drop_write", last_rdata, old_val);

    for (int t = 0; t < 400; t++) begin
      r  = $urandom_range(0, 99);
      r2 = $urandom_range(0, 99);
      sz = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if (r2 < 5)       a = 32'h1000 + 32'($urandom_range(0, 65535));
      else if (r2 < 35) a = (p_addr & 32'hFFC) | 32'($urandom_range(0, 3));
      else              a = 32'($urandom_range(0, 255));
      if (r < 10)
        step(1'b0, HTRANS_NONSEQ, 1'($urandom), a, sz, $urandom);
      else if (r < 20)
        step(1'b1, 2'($urandom_range(0, 1)), 1'($urandom), a, sz, $urandom);
      else
        step(1'b1, ($urandom_range(0, 1) != 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
             1'($urandom), a, sz, $urandom);
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, word-address width; memory is 2^MEM_AW 32-bit words (4 KB default).
REQ-002 SHALL have port hclk, input, 1, single clock; all logic on its rising edge.
REQ-003 SHALL have port hreset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have ports hsel (in, 1), haddr (in, 32), htrans (in, 2), hwrite (in, 1), hsize (in, 3), hburst (in, 3), hwdata (in, 32), hready (in, 1, bus-level ready).
REQ-005 SHALL have outputs hreadyout (1, slave ready), hresp (2, 0=OKAY, 1=ERROR), hrdata (32).

Function
REQ-006 SHALL accept an address phase only when hsel=1, hready=1 and htrans is NONSEQ(2) or SEQ(3); IDLE(0)/BUSY(1) SHALL get a zero-wait OKAY with no memory access.
REQ-007 SHALL register haddr, hwrite and hsize at acceptance; hburst SHALL be ignored, because every beat carries its own address.
REQ-008 SHALL implement FSM states IDLE, WRITE, READ, RD_WAIT, ERR1 and ERR2, with transitions decided only on accepted address phases and hready.
REQ-009 SHALL flag an error when the access is out of range (haddr[31:MEM_AW+2] != 0), misaligned (half with haddr[0]=1, word with haddr[1:0] != 0) or hsize > 2.
REQ-010 On an error it SHALL go to ERR1 (hreadyout=0, hresp=ERROR), then ERR2 (hreadyout=1, hresp=ERROR), and SHALL perform no memory access.
REQ-011 A write data phase SHALL be zero-wait; hwdata is committed at the edge ending the data phase.
REQ-012 The write SHALL use little-endian byte enables: byte lane = haddr[1:0]; half covers lanes {haddr[1],0} and {haddr[1],1}; word covers all four lanes.
REQ-013 A read SHALL issue the RAM read at the address-phase edge, and hrdata SHALL be valid in the data phase with hreadyout=1.
REQ-014 Read-after-write hazard: when a read address phase overlaps a write data phase to the same word, hrdata SHALL be a byte-wise merge, with written lanes taken from hwdata and the other lanes from RAM.
REQ-015 Back-to-back accepted transfers SHALL sustain one transfer per cycle, except in the error and wait-state paths.
REQ-016 hrdata SHALL be 0 outside a read data phase with hreadyout=1, and SHALL return the full 32-bit word regardless of hsize.
REQ-017 An accepted address phase during ERR2 SHALL be processed normally in the next cycle.

Reset
REQ-018 While hreset=1 the block SHALL force IDLE, hreadyout=1, hresp=OKAY and hrdata=0.
REQ-019 A reset asserted mid-transfer SHALL discard any pending write, so no RAM write occurs at the reset edge.
REQ-020 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-021 Macro AHB_SRAM_RD_WAIT_EN defined: each read data phase SHALL first pass through RD_WAIT (hreadyout=0, one cycle) before READ, and the hazard merge SHALL still apply.
REQ-022 Macro AHB_SRAM_RD_WAIT_EN undefined: the RD_WAIT state SHALL be absent and reads SHALL be zero-wait.

Structure
REQ-023 Package ahb_sram_pkg SHALL hold the htrans, hsize and hresp encodings, the FSM state enum and the 32-bit data/address width constants.
REQ-024 The block SHALL instantiate one sub-module, sram_1r1w_be: a synchronous 1-read-1-write RAM with 4 byte enables and read-old-data on collision.

Verification
REQ-025 Word write 0xDEADBEEF @0x10, then word read @0x10 -> hrdata=0xDEADBEEF, OKAY, zero-wait (no macro).
REQ-026 Byte write 0xAA @0x13 after word write 0x11223344 @0x10, with read @0x10 back-to-back in the overlapping cycle -> hrdata=0xAA223344 (forwarded).
REQ-027 Word read @0x1000 with MEM_AW=10 -> ERR1 cycle (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), and RAM is untouched.
REQ-028 Half write @0x21 -> two-cycle ERROR; a subsequent word read @0x20 returns the prior contents.
REQ-029 With AHB_SRAM_RD_WAIT_EN, read @0x10 -> one cycle hreadyout=0, then hrdata valid; back-to-back writes remain zero-wait.
REQ-030 Assert hreset during a write data phase of 0x55 @0x30 -> next read @0x30 returns the old value, with outputs at reset values during reset.
